// File: rtl/vga_color_bar_pkg.sv
// Shared timing defaults, total-period derivation and colour-bar table for vga_color_bar.
// Bar pattern is selected by the VGA_COLOR_BAR_PATTERN_EN macro in the top.
package vga_color_bar_pkg;

    localparam int CNT_W = 12;
    localparam int COL_W = 5;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef struct packed {
        logic [COL_W-1:0] r;
        logic [COL_W-1:0] g;
        logic [COL_W-1:0] b;
    } rgb_t;

    typedef enum logic [2:0] {
        BAR_WHITE   = 3'd0,
        BAR_YELLOW  = 3'd1,
        BAR_CYAN    = 3'd2,
        BAR_GREEN   = 3'd3,
        BAR_MAGENTA = 3'd4,
        BAR_RED     = 3'd5,
        BAR_BLUE    = 3'd6,
        BAR_BLACK   = 3'd7
    } bar_e;

    function automatic int total_of(input int sync, input int bp, input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

    localparam int H_TOTAL_DEF = total_of(H_SYNC_DEF, H_BP_DEF, H_ACTIVE_DEF, H_FP_DEF);
    localparam int V_TOTAL_DEF = total_of(V_SYNC_DEF, V_BP_DEF, V_ACTIVE_DEF, V_FP_DEF);

    function automatic rgb_t bar_colour(input bar_e bar);
        rgb_t c;
        c = {5'h00, 5'h00, 5'h00};
        case (bar)
            BAR_WHITE:   c = {5'h1F, 5'h1F, 5'h1F};
            BAR_YELLOW:  c = {5'h1F, 5'h1F, 5'h00};
            BAR_CYAN:    c = {5'h00, 5'h1F, 5'h1F};
            BAR_GREEN:   c = {5'h00, 5'h1F, 5'h00};
            BAR_MAGENTA: c = {5'h1F, 5'h00, 5'h1F};
            BAR_RED:     c = {5'h1F, 5'h00, 5'h00};
            BAR_BLUE:    c = {5'h00, 5'h00, 5'h1F};
            BAR_BLACK:   c = {5'h00, 5'h00, 5'h00};
            default:     c = {5'h00, 5'h00, 5'h00};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters with combinational sync, data-enable and coordinate decode.
// Decoded outputs are valid in the same cycle as the counter registers.
module vga_timing_gen
    import vga_color_bar_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             vga_clk,
    input  logic             rst_n,
    output logic             h_sync,
    output logic             v_sync,
    output logic             de,
    output logic [CNT_W-1:0] coord_x,
    output logic [CNT_W-1:0] coord_y
);

    localparam int H_TOTAL = total_of(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = total_of(V_SYNC, V_BP, V_ACTIVE, V_FP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_START  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_END    = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_START  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_END    = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic             h_active_s;
    logic             v_active_s;

    // Pixel and line counters; the line counter advances on each pixel-counter wrap.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r <= 12'd0;
            v_cnt_r <= 12'd0;
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= 12'd0;
            if (v_cnt_r == V_LAST) begin
                v_cnt_r <= 12'd0;
            end else begin
                v_cnt_r <= v_cnt_r + 12'd1;
            end
        end else begin
            h_cnt_r <= h_cnt_r + 12'd1;
            v_cnt_r <= v_cnt_r;
        end
    end

    // Sync, active-window and coordinate decode from the current counter values.
    always_comb begin
        h_active_s = (h_cnt_r >= H_START) && (h_cnt_r < H_END);
        v_active_s = (v_cnt_r >= V_START) && (v_cnt_r < V_END);
        h_sync     = (h_cnt_r >= H_SYNC_C);
        v_sync     = (v_cnt_r >= V_SYNC_C);
        de         = h_active_s && v_active_s;
        if (h_active_s) begin
            coord_x = h_cnt_r - H_START;
        end else begin
            coord_x = 12'd0;
        end
        if (v_active_s) begin
            coord_y = v_cnt_r - V_START;
        end else begin
            coord_y = 12'd0;
        end
    end

endmodule

// File: rtl/vga_color_bar.sv
// VGA timing plus one-clock registered colour output (upper 5 bits of each 10-bit input).
// Define VGA_COLOR_BAR_PATTERN_EN to replace the inputs with an internal 8-bar test pattern.
module vga_color_bar
    import vga_color_bar_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             iCLK,
    input  logic             rst_n,
    input  logic [9:0]       iRed,
    input  logic [9:0]       iGreen,
    input  logic [9:0]       iBlue,
    output logic [CNT_W-1:0] oCoord_X,
    output logic [CNT_W-1:0] oCoord_Y,
    output logic [COL_W-1:0] oVGA_R,
    output logic [COL_W-1:0] oVGA_G,
    output logic [COL_W-1:0] oVGA_B,
    output logic             oVGA_H_SYNC,
    output logic             oVGA_V_SYNC,
    output logic             oVGA_DE,
    output logic             oVGA_SYNC,
    output logic             oVGA_BLANK,
    output logic             oVGA_CLOCK
);

    logic             h_sync_s;
    logic             v_sync_s;
    logic             de_s;
    logic [CNT_W-1:0] x_s;
    logic [CNT_W-1:0] y_s;
    rgb_t             pix_s;
    rgb_t             rgb_r;
    logic             unused_s;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .vga_clk (iCLK),
        .rst_n   (rst_n),
        .h_sync  (h_sync_s),
        .v_sync  (v_sync_s),
        .de      (de_s),
        .coord_x (x_s),
        .coord_y (y_s)
    );

`ifdef VGA_COLOR_BAR_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
    logic [CNT_W-1:0] bar_idx_s;

    // Bar index from the active X coordinate selects a fixed colour.
    always_comb begin
        bar_idx_s = x_s / BAR_W;
        pix_s     = bar_colour(bar_e'(bar_idx_s[2:0]));
    end

    assign unused_s = ^{iRed, iGreen, iBlue, bar_idx_s[CNT_W-1:3]};
`else
    // Pass-through keeps only the top five bits of each channel.
    always_comb begin
        pix_s.r = iRed[9:5];
        pix_s.g = iGreen[9:5];
        pix_s.b = iBlue[9:5];
    end

    assign unused_s = ^{iRed[4:0], iGreen[4:0], iBlue[4:0]};
`endif

    // Colour register: blanked to zero for the clock after any cycle outside the active window.
    always_ff @(posedge iCLK or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r <= 15'd0;
        end else if (de_s) begin
            rgb_r <= pix_s;
        end else begin
            rgb_r <= 15'd0;
        end
    end

    assign oCoord_X    = x_s;
    assign oCoord_Y    = y_s;
    assign oVGA_R      = rgb_r.r;
    assign oVGA_G      = rgb_r.g;
    assign oVGA_B      = rgb_r.b;
    assign oVGA_H_SYNC = h_sync_s;
    assign oVGA_V_SYNC = v_sync_s;
    assign oVGA_DE     = de_s;
    assign oVGA_SYNC   = 1'b0;
    assign oVGA_BLANK  = h_sync_s & v_sync_s;
    assign oVGA_CLOCK  = iCLK;

endmodule

// File: tb/tb_vga_color_bar.sv
// Self-checking bench: default-timing instance plus a shrunken-timing instance, both checked
// every cycle against an arithmetic timing model with colour scoreboards.
module tb_vga_color_bar;

    localparam int BH_A = 640, BH_F = 16, BH_S = 96, BH_B = 48;
    localparam int BV_A = 480, BV_F = 10, BV_S = 2,  BV_B = 33;
    localparam int SH_A = 16,  SH_F = 2,  SH_S = 3,  SH_B = 4;
    localparam int SV_A = 8,   SV_F = 1,  SV_S = 2,  SV_B = 2;
    localparam int S_FRAME = 25 * 13;
    localparam int RUN_LEN = 28144 + 800 + 10;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
    } col_t;

    typedef struct packed {
        logic [9:0] ir;
        logic [9:0] ig;
        logic [9:0] ib;
        logic [4:0] er;
        logic [4:0] eg;
        logic [4:0] eb;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [9:0]  b_ir, b_ig, b_ib, s_ir, s_ig, s_ib;
    logic [11:0] b_x, b_y, s_x, s_y;
    logic [4:0]  b_r, b_g, b_b, s_r, s_g, s_b;
    logic        b_hs, b_vs, b_de, b_sy, b_bl, b_ck;
    logic        s_hs, s_vs, s_de, s_sy, s_bl, s_ck;

    vga_color_bar u_big (
        .iCLK(clk), .rst_n(rst_n), .iRed(b_ir), .iGreen(b_ig), .iBlue(b_ib),
        .oCoord_X(b_x), .oCoord_Y(b_y), .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b),
        .oVGA_H_SYNC(b_hs), .oVGA_V_SYNC(b_vs), .oVGA_DE(b_de), .oVGA_SYNC(b_sy),
        .oVGA_BLANK(b_bl), .oVGA_CLOCK(b_ck)
    );

    vga_color_bar #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B)
    ) u_small (
        .iCLK(clk), .rst_n(rst_n), .iRed(s_ir), .iGreen(s_ig), .iBlue(s_ib),
        .oCoord_X(s_x), .oCoord_Y(s_y), .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b),
        .oVGA_H_SYNC(s_hs), .oVGA_V_SYNC(s_vs), .oVGA_DE(s_de), .oVGA_SYNC(s_sy),
        .oVGA_BLANK(s_bl), .oVGA_CLOCK(s_ck)
    );

    col_t q_b[$];
    col_t q_s[$];
    vec_t vecs[4];
    int   n;
    int   mode;
    int   cur_vec;
    int   chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
    int   first_de, fx, fy, hs_low, vs_low, de_line;
    int   fall1, fall2, max_x, max_y, sq_cnt;
    logic prev_svs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            if (fail_cnt <= 20)
                $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic model(input int nn, input int hs, input int hb, input int ha, input int hf,
                         input int vs, input int vb, input int va, input int vf,
                         output logic hsy, output logic vsy, output logic de,
                         output int x, output int y);
        int ht, vt, h, v;
        logic hact, vact;
        ht   = hs + hb + ha + hf;
        vt   = vs + vb + va + vf;
        h    = nn % ht;
        v    = (nn / ht) % vt;
        hsy  = (h >= hs);
        vsy  = (v >= vs);
        hact = (h >= hs + hb) && (h < hs + hb + ha);
        vact = (v >= vs + vb) && (v < vs + vb + va);
        de   = hact && vact;
        x    = hact ? h - (hs + hb) : 0;
        y    = vact ? v - (vs + vb) : 0;
    endtask

    function automatic col_t bar_exp(input int x, input int ha);
        int   bar;
        col_t c;
        bar = x / (ha / 8);
        c.r = (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 5'h1F : 5'h00;
        c.g = (bar < 4) ? 5'h1F : 5'h00;
        c.b = (bar % 2 == 0) ? 5'h1F : 5'h00;
        return c;
    endfunction

    task automatic reset_stats();
        first_de = -1; fx = -1; fy = -1; hs_low = 0; vs_low = 0; de_line = 0;
        fall1 = -1; fall2 = -1; max_x = 0; max_y = 0; sq_cnt = 0; prev_svs = 1'b0;
    endtask

    task automatic check_cycle();
        logic bh, bv, bd, sh, sv, sd;
        int   bx, by, sx, sy;
        col_t e;
        model(n, BH_S, BH_B, BH_A, BH_F, BV_S, BV_B, BV_A, BV_F, bh, bv, bd, bx, by);
        model(n, SH_S, SH_B, SH_A, SH_F, SV_S, SV_B, SV_A, SV_F, sh, sv, sd, sx, sy);
        chk("big_hsync", b_hs, bh);   chk("big_vsync", b_vs, bv);
        chk("big_de", b_de, bd);      chk("big_blank", b_bl, bh & bv);
        chk("big_x", b_x, bx);        chk("big_y", b_y, by);
        chk("big_sync", b_sy, 1'b0);  chk("big_clock", b_ck, clk);
        chk("sm_hsync", s_hs, sh);    chk("sm_vsync", s_vs, sv);
        chk("sm_de", s_de, sd);       chk("sm_blank", s_bl, sh & sv);
        chk("sm_x", s_x, sx);         chk("sm_y", s_y, sy);
        chk("sm_sync", s_sy, 1'b0);
        if (q_b.size() == 0) begin
            chk("big_sb_underflow", 1, 0);
        end else begin
            e = q_b.pop_front();
            chk("big_rgb", {b_r, b_g, b_b}, e);
        end
        if (q_s.size() == 0) begin
            chk("sm_sb_underflow", 1, 0);
        end else begin
            e = q_s.pop_front();
            chk("sm_rgb", {s_r, s_g, s_b}, e);
        end
        if (rst_n) begin
            if (b_de && first_de < 0) begin
                first_de = n; fx = b_x; fy = b_y;
            end
            if (n < 800 && !b_hs) hs_low++;
            if (!b_vs) vs_low++;
            if (n >= 28000 && n < 28800 && b_de) de_line++;
            if (prev_svs && !s_vs) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            prev_svs = s_vs;
            if (s_de && int'(s_x) > max_x) max_x = s_x;
            if (s_de && int'(s_y) > max_y) max_y = s_y;
            if (mode == 1 && s_r == 5'h1F) sq_cnt++;
        end
    endtask

    task automatic drive_cycle();
        logic bh, bv, bd, sh, sv, sd;
        int   bx, by, sx, sy;
        col_t eb, es;
        model(n, BH_S, BH_B, BH_A, BH_F, BV_S, BV_B, BV_A, BV_F, bh, bv, bd, bx, by);
        model(n, SH_S, SH_B, SH_A, SH_F, SV_S, SV_B, SV_A, SV_F, sh, sv, sd, sx, sy);
        b_ir = 10'h3FF;
        b_ig = 10'(n * 7);
        b_ib = 10'($urandom);
        eb   = {b_ir[9:5], b_ig[9:5], b_ib[9:5]};
        if (mode == 0) begin
            s_ir = vecs[cur_vec].ir; s_ig = vecs[cur_vec].ig; s_ib = vecs[cur_vec].ib;
            es   = {vecs[cur_vec].er, vecs[cur_vec].eg, vecs[cur_vec].eb};
        end else if (mode == 1) begin
            s_ir = (sd && sx < 3 && sy < 3) ? 10'h3FF : 10'h000;
            s_ig = 10'h000; s_ib = 10'h000;
            es   = {s_ir[9:5], 5'h00, 5'h00};
        end else begin
            s_ir = 10'($urandom); s_ig = 10'($urandom); s_ib = 10'($urandom);
            es   = {s_ir[9:5], s_ig[9:5], s_ib[9:5]};
        end
`ifdef VGA_COLOR_BAR_PATTERN_EN
        eb = bar_exp(bx, BH_A);
        es = bar_exp(sx, SH_A);
`endif
        q_b.push_back(bd ? eb : 15'd0);
        q_s.push_back(sd ? es : 15'd0);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_cycle();
        drive_cycle();
        @(posedge clk);
        #2;
        if (rst_n) n++;
    endtask

    task automatic check_phase(input int with_square);
        chk("first_de_clock", first_de, 28144);
        chk("first_de_x", fx, 0);
        chk("first_de_y", fy, 0);
        chk("hsync_low_per_line", hs_low, 96);
        chk("vsync_low_per_frame", vs_low, 1600);
        chk("de_per_line", de_line, 640);
        chk("sm_frame_period", fall2 - fall1, S_FRAME);
        chk("sm_last_x", max_x, SH_A - 1);
        chk("sm_last_y", max_y, SV_A - 1);
`ifndef VGA_COLOR_BAR_PATTERN_EN
        if (with_square != 0) chk("sm_square_pixels", sq_cnt, 9);
`endif
    endtask

    task automatic check_async_reset();
        chk("rst_big_hsync", b_hs, 1'b0); chk("rst_big_vsync", b_vs, 1'b0);
        chk("rst_big_blank", b_bl, 1'b0); chk("rst_big_de", b_de, 1'b0);
        chk("rst_big_xy", {b_x, b_y}, 24'd0);
        chk("rst_big_rgb", {b_r, b_g, b_b}, 15'd0);
        chk("rst_sm_de", s_de, 1'b0);
        chk("rst_sm_rgb", {s_r, s_g, s_b}, 15'd0);
    endtask

    initial begin
        vecs[0] = '{ir: 10'h3FF, ig: 10'h000, ib: 10'h01F, er: 5'h1F, eg: 5'h00, eb: 5'h00};
        vecs[1] = '{ir: 10'h020, ig: 10'h3E0, ib: 10'h2A5, er: 5'h01, eg: 5'h1F, eb: 5'h15};
        vecs[2] = '{ir: 10'h1FF, ig: 10'h200, ib: 10'h3FF, er: 5'h0F, eg: 5'h10, eb: 5'h1F};
        vecs[3] = '{ir: 10'h155, ig: 10'h0AA, ib: 10'h000, er: 5'h0A, eg: 5'h05, eb: 5'h00};
        rst_n = 1'b0; n = 0; mode = 0; cur_vec = 0;
        b_ir = 10'h000; b_ig = 10'h000; b_ib = 10'h000;
        s_ir = 10'h000; s_ig = 10'h000; s_ib = 10'h000;
        q_b.push_back(15'd0);
        q_s.push_back(15'd0);
        reset_stats();
        repeat (3) cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            cur_vec = i;
            repeat (S_FRAME) cycle();
        end
        mode = 1;
        repeat (S_FRAME) cycle();
        mode = 2;
        repeat (RUN_LEN - n) cycle();
        check_phase(1);

        // Mid-line asynchronous reset, then a full restart of the timing.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_async_reset();
        q_b.delete(); q_s.delete();
        q_b.push_back(15'd0); q_s.push_back(15'd0);
        n = 0;
        reset_stats();
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (RUN_LEN) cycle();
        check_phase(0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/vga_color_bar.md
VGA_COLOR_BAR -- requirements
Module: vga_color_bar

Interface
REQ-001 Parameter H_ACTIVE, 640, active pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, 16/96/48, horizontal front porch, sync and back porch in clocks.
REQ-003 Parameter V_ACTIVE, 480, active lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, 10/2/33, vertical front porch, sync and back porch in lines.
REQ-005 iCLK  in  1  pixel clock; the single clock.
REQ-006 rst_n  in  1  reset; one clock, asynchronous active-low reset.
REQ-007 iRed, iGreen, iBlue  in  10 each  pixel colour for the current coordinate.
REQ-008 oCoord_X, oCoord_Y  out  12 each  current active-pixel coordinate.
REQ-009 oVGA_R, oVGA_G, oVGA_B  out  5 each  colour output.
REQ-010 oVGA_H_SYNC, oVGA_V_SYNC  out  1 each  syncs, active-low.
REQ-011 oVGA_DE  out  1  data enable; oVGA_SYNC  out  1  constant 0; oVGA_BLANK  out  1  oVGA_H_SYNC AND oVGA_V_SYNC; oVGA_CLOCK  out  1  equals iCLK.

Function
REQ-012 12-bit h_cnt counts 0..H_TOTAL-1 (H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP = 800) and wraps to 0.
REQ-013 12-bit v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1 (525), wraps to 0.
REQ-014 oVGA_H_SYNC = 0 while h_cnt < H_SYNC, else 1; oVGA_V_SYNC = 0 while v_cnt < V_SYNC, else 1.
REQ-015 h_active: H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE; v_active is the same with V parameters; oVGA_DE = h_active AND v_active.
REQ-016 oCoord_X = h_cnt-(H_SYNC+H_BP) and oCoord_Y = v_cnt-(V_SYNC+V_BP) while the respective active flag is 1, else 0.
REQ-017 Syncs, DE and coordinates are decoded from the counter registers and are valid in the same cycle as the counters.
REQ-018 Colour is registered with 1-clock latency: oVGA_x <= oVGA_DE ? iColour[9:5] : 0, sampling iColour in the cycle where DE/coordinates are presented.
REQ-019 Colour outputs are 0 on the clock after any cycle with oVGA_DE = 0, including the last active pixel+1 and the whole vertical blank.
REQ-020 Callers delay syncs/DE/coordinates by one clock externally to align with colour; this block adds no delay to them.

Reset
REQ-021 While rst_n = 0: h_cnt = v_cnt = 0; colour outputs 0; oVGA_DE 0; coordinates 0; oVGA_H_SYNC = oVGA_V_SYNC = oVGA_BLANK = 0.
REQ-022 Reset asserted mid-frame restarts timing at h_cnt = v_cnt = 0 on release; no partial-line state is retained.

Configuration
REQ-023 Macro VGA_COLOR_BAR_PATTERN_EN: when defined, colour comes from an internal 8 vertical bar pattern (bar = oCoord_X/(H_ACTIVE/8): white, yellow, cyan, green, magenta, red, blue, black; each channel 5'h1F or 0), and iRed/iGreen/iBlue are ignored.
REQ-024 When the macro is undefined, colour passes through per REQ-018; timing is identical in both builds.

Structure
REQ-025 Package vga_color_bar_pkg holds default timing constants, the H_TOTAL/V_TOTAL derivations and the bar colour table.
REQ-026 Sub-module vga_timing_gen holds the counters and the sync/DE/coordinate decode; the top holds the colour register and pattern mux.

Verification
REQ-027 Release reset, default parameters -> first oVGA_DE = 1 at clock 28144 (v=35, h=144) with coordinates (0,0); oVGA_DE = 1 for exactly 640 clocks per line.
REQ-028 Count clocks -> oVGA_H_SYNC low 96 of every 800 clocks; oVGA_V_SYNC low 1600 clocks per frame; frame period 420000 clocks; oVGA_BLANK = H AND V at all times.
REQ-029 iRed = 10'h3FF only while DE and oCoord_X < 30 and oCoord_Y < 30 -> oVGA_R = 5'h1F exactly one clock later for 30x30 pixels, 0 elsewhere.
REQ-030 iRed = 10'h3FF held constant -> oVGA_R = 0 one clock after every DE = 0 cycle; last active X = 639, Y = 479.
REQ-031 Assert rst_n low mid-line at v=100 -> all outputs reach reset values immediately; after release the first DE occurs again at clock 28144.
REQ-032 With VGA_COLOR_BAR_PATTERN_EN defined -> at oCoord_X = 0/80/560 on the next clock RGB = 1F,1F,1F / 1F,1F,00 / 00,00,00, independent of the inputs.
